// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: FP instruction issue queue with valid/ready issue to the FPU.
// Define FPU_IQ_SCOREBOARD_EN to build the FMA/div-sqrt hazard scoreboard.
module fpu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int FMA_LAT = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       io_enq_valid,
    output logic                       io_enq_ready,
    input  logic [31:0]                io_enq_inst,
    input  logic [13:0]                io_enq_sigs,
    output logic                       io_deq_valid,
    input  logic                       io_deq_ready,
    output logic [31:0]                io_deq_inst,
    output logic [13:0]                io_deq_sigs,
    input  logic                       io_divsqrt_done,
    input  logic                       io_kill,
    output logic [$clog2(DEPTH+1)-1:0] io_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   inst_q [DEPTH];
    logic [13:0]   sigs_q [DEPTH];
    logic [AW-1:0] head, tail;
    logic          enq, deq, stall;

    assign io_enq_ready = io_count < CW'(DEPTH);
    assign enq          = io_enq_valid && io_enq_ready && !io_kill;
    assign io_deq_inst  = inst_q[head];
    assign io_deq_sigs  = sigs_q[head];
    assign io_deq_valid = (io_count != '0) && !stall && !io_kill;
    assign deq          = io_deq_valid && io_deq_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            io_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                sigs_q[i] <= '0;
            end
        end else if (io_kill) begin
            head     <= '0;
            tail     <= '0;
            io_count <= '0;
        end else begin
            if (enq) begin
                inst_q[tail] <= io_enq_inst;
                sigs_q[tail] <= io_enq_sigs;
                tail         <= tail + AW'(1);
            end
            if (deq)
                head <= head + AW'(1);
            io_count <= io_count + CW'(enq) - CW'(deq);
        end
    end

`ifdef FPU_IQ_SCOREBOARD_EN
    logic        fma_v  [FMA_LAT];
    logic [4:0]  fma_rd [FMA_LAT];
    logic        ds_busy, ds_wen;
    logic [4:0]  ds_rd;
    logic [31:0] pend;
    logic [4:0]  rs1, rs2, rs3, rd;
    logic        is_ds;

    assign rs1   = io_deq_inst[19:15];
    assign rs2   = io_deq_inst[24:20];
    assign rs3   = io_deq_inst[31:27];
    assign rd    = io_deq_inst[11:7];
    assign is_ds = io_deq_sigs[2] | io_deq_sigs[1];

    // One-hot view of every register with a result still in flight
    always_comb begin
        pend = '0;
        for (int i = 0; i < FMA_LAT; i++)
            if (fma_v[i]) pend[fma_rd[i]] = 1'b1;
        if (ds_busy && ds_wen) pend[ds_rd] = 1'b1;
    end

    assign stall = (io_deq_sigs[12] & pend[rs1]) | (io_deq_sigs[11] & pend[rs2]) |
                   (io_deq_sigs[10] & pend[rs3]) | (io_deq_sigs[13] & pend[rd])  |
                   (is_ds & ds_busy);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FMA_LAT; i++) begin
                fma_v[i]  <= 1'b0;
                fma_rd[i] <= '0;
            end
            ds_busy <= 1'b0;
            ds_wen  <= 1'b0;
            ds_rd   <= '0;
        end else begin
            fma_v[0]  <= deq && io_deq_sigs[3] && io_deq_sigs[13];
            fma_rd[0] <= rd;
            for (int i = 1; i < FMA_LAT; i++) begin
                fma_v[i]  <= fma_v[i-1];
                fma_rd[i] <= fma_rd[i-1];
            end
            if (deq && is_ds) begin
                ds_busy <= 1'b1;
                ds_rd   <= rd;
                ds_wen  <= io_deq_sigs[13];
            end else if (io_divsqrt_done) begin
                ds_busy <= 1'b0;
            end
        end
    end
`else
    logic unused_ok;

    assign stall     = 1'b0;
    assign unused_ok = io_divsqrt_done | (FMA_LAT == 0);
`endif
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue: directed + random checks of fpu_issue_queue against a queue/timestamp model.
module tb_fpu_issue_queue;
    localparam int DEPTH   = 4;
    localparam int FMA_LAT = 3;
`ifdef FPU_IQ_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    localparam logic [13:0] WEN = 14'h2000, REN1 = 14'h1000, REN2 = 14'h0800, REN3 = 14'h0400;
    localparam logic [13:0] FAST = 14'h0010, FMA = 14'h0008, DIV = 14'h0004;

    logic        clock = 0, reset_n = 0;
    logic        io_enq_valid = 0, io_enq_ready, io_deq_valid, io_deq_ready = 0;
    logic [31:0] io_enq_inst = 0, io_deq_inst;
    logic [13:0] io_enq_sigs = 0, io_deq_sigs;
    logic        io_divsqrt_done = 0, io_kill = 0;
    logic [2:0]  io_count;

    fpu_issue_queue #(.DEPTH(DEPTH), .FMA_LAT(FMA_LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
        .io_enq_inst(io_enq_inst), .io_enq_sigs(io_enq_sigs),
        .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready),
        .io_deq_inst(io_deq_inst), .io_deq_sigs(io_deq_sigs),
        .io_divsqrt_done(io_divsqrt_done), .io_kill(io_kill), .io_count(io_count)
    );

    always #5 clock = ~clock;

    logic [45:0] q [$];
    int          last_fma [32];
    bit          ds_busy_m, ds_wen_m;
    logic [4:0]  ds_rd_m;
    int          cyc, checks, errors, n0;
    int          iss_edge [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) last_fma[i] = -1000;
        ds_busy_m = 0;
        ds_wen_m  = 0;
        ds_rd_m   = 0;
    endtask

    // Register r has a result in flight during the current cycle
    function automatic bit pend(input logic [4:0] r);
        int d = cyc - last_fma[r];
        return (d >= 0 && d < FMA_LAT) || (ds_busy_m && ds_wen_m && ds_rd_m == r);
    endfunction

    function automatic bit stall_m();
        logic [31:0] i;
        logic [13:0] s;
        if (!SB || q.size() == 0) return 0;
        i = q[0][45:14];
        s = q[0][13:0];
        return (s[12] && pend(i[19:15])) || (s[11] && pend(i[24:20])) ||
               (s[10] && pend(i[31:27])) || (s[13] && pend(i[11:7])) ||
               ((s[2] || s[1]) && ds_busy_m);
    endfunction

    task automatic step();
        bit          er, ev, fire;
        logic [31:0] hi;
        logic [13:0] hs;
        #3;
        er = q.size() < DEPTH;
        ev = q.size() != 0 && !stall_m() && !io_kill;
        chk("enq_ready", io_enq_ready, er);
        chk("count", io_count, q.size());
        chk("deq_valid", io_deq_valid, ev);
        if (q.size() != 0) begin
            chk("deq_inst", io_deq_inst, q[0][45:14]);
            chk("deq_sigs", io_deq_sigs, q[0][13:0]);
        end
        if (io_deq_valid && io_deq_ready) iss_edge.push_back(cyc + 1);
        fire = ev && io_deq_ready;
        hi = fire ? q[0][45:14] : 32'h0;
        hs = fire ? q[0][13:0] : 14'h0;
        if (SB && fire && hs[3] && hs[13]) last_fma[hi[11:7]] = cyc + 1;
        if (SB && fire && (hs[2] || hs[1])) begin
            ds_busy_m = 1;
            ds_rd_m   = hi[11:7];
            ds_wen_m  = hs[13];
        end else if (io_divsqrt_done) begin
            ds_busy_m = 0;
        end
        if (io_kill) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (io_enq_valid && er) q.push_back({io_enq_inst, io_enq_sigs});
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [31:0] i, input logic [13:0] s);
        io_enq_valid = 1;
        io_enq_inst  = i;
        io_enq_sigs  = s;
        step();
        io_enq_valid = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_enq_ready"}, io_enq_ready, 1);
        chk({tag, "_deq_valid"}, io_deq_valid, 0);
        chk({tag, "_count"}, io_count, 0);
        chk({tag, "_deq_inst"}, io_deq_inst, 0);
        chk({tag, "_deq_sigs"}, io_deq_sigs, 0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_values("reset");
        @(negedge clock);
        reset_n = 1;
        @(posedge clock);
        #1;

        // Fill past capacity, then drain in order
        for (int k = 0; k < 5; k++) put(32'h0000_0053 | (32'(k + 9) << 7), WEN | FAST);
        chk("fill_count", io_count, DEPTH);
        chk("fill_enq_ready", io_enq_ready, 0);
        io_deq_ready = 1;
        run(4);
        chk("drain_count", io_count, 0);

        // FMA result feeding a dependent fadd
        n0 = iss_edge.size();
        put(32'h2020_81C3, FMA | WEN | REN1 | REN2 | REN3);
        put(32'h0001_82D3, WEN | REN1 | REN2);
        run(8);
        chk("fma_raw_issued", iss_edge.size() - n0, 2);
        chk("fma_raw_gap", iss_edge[n0+1] - iss_edge[n0], SB ? 4 : 1);

        // Independent op behind a pending FMA
        n0 = iss_edge.size();
        put(32'h2020_81C3, FMA | WEN | REN1 | REN2 | REN3);
        put(32'h0020_83D3, WEN | REN1 | REN2);
        run(3);
        chk("indep_gap", iss_edge[n0+1] - iss_edge[n0], 1);

        // Second fdiv waits for the divider
        n0 = iss_edge.size();
        put(32'h1820_8353, DIV | WEN | REN1 | REN2);
        put(32'h1820_8453, DIV | WEN | REN1 | REN2);
        run(5);
        chk("div_before_done", iss_edge.size() - n0, SB ? 1 : 2);
        io_divsqrt_done = 1;
        step();
        io_divsqrt_done = 0;
        run(3);
        chk("div_after_done", iss_edge.size() - n0, 2);

        // Kill flushes entries and drops the concurrent enqueue
        io_deq_ready = 0;
        for (int k = 0; k < 3; k++) put(32'h0000_0053 | (32'(k + 20) << 7), WEN | FAST);
        io_enq_valid = 1;
        io_kill = 1;
        step();
        io_kill = 0;
        io_enq_valid = 0;
        step();
        chk("kill_count", io_count, 0);

        // Asynchronous reset while the divider is busy and the queue holds entries
        io_deq_ready = 1;
        put(32'h1820_8553, DIV | WEN | REN1 | REN2);
        run(2);
        io_deq_ready = 0;
        put(32'h0000_0653, WEN | FAST);
        #2;
        reset_n = 0;
        #1;
        chk_reset_values("async_reset");
        model_reset();
        #2;
        reset_n = 1;
        @(posedge clock);
        #1;
        io_deq_ready = 1;
        n0 = iss_edge.size();
        put(32'h1820_8753, DIV | WEN | REN1 | REN2);
        run(2);
        chk("div_after_reset", iss_edge.size() - n0, 1);

        // Random traffic on a small register set to provoke hazards
        repeat (600) begin
            logic [31:0] i;
            logic [13:0] s;
            i = $urandom;
            i[19:15] = 5'($urandom_range(0, 3));
            i[24:20] = 5'($urandom_range(0, 3));
            i[31:27] = 5'($urandom_range(0, 3));
            i[11:7]  = 5'($urandom_range(0, 3));
            s = 14'($urandom);
            if ($urandom % 6 != 0) s[2:1] = 2'b00;
            io_enq_valid    = ($urandom % 4) != 0;
            io_enq_inst     = i;
            io_enq_sigs     = s;
            io_deq_ready    = ($urandom % 4) != 0;
            io_divsqrt_done = ($urandom % 5) == 0;
            io_kill         = ($urandom % 25) == 0;
            step();
        end
        io_enq_valid = 0;
        io_kill = 0;
        io_divsqrt_done = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

FP instruction issue queue between the FPU decoder and the FPU execution pipes. It buffers up to DEPTH instructions together with their 14 decoded control signals and holds the queue head back on register hazards and on the iterative div/sqrt unit being busy. It presents one instruction per cycle to the FPU over a valid/ready handshake.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- FMA_LAT, 3: cycles an issued FMA-class result is pending, ≥1
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_enq_valid  in  1  decoder has an instruction
- io_enq_ready  out  1  queue can accept
- io_enq_inst  in  32  raw instruction
- io_enq_sigs  in  14  decoded sigs: [13]wen [12]ren1 [11]ren2 [10]ren3 [9]swap12 [8]swap23 [7]singleOut [6]fromint [5]toint [4]fastpipe [3]fma [2]div [1]sqrt [0]wflags
- io_deq_valid  out  1  head is issuable
- io_deq_ready  in  1  FPU accepts
- io_deq_inst  out  32  head instruction
- io_deq_sigs  out  14  head sigs, same packing
- io_divsqrt_done  in  1  div/sqrt unit finished its operation
- io_kill  in  1  flush all queued (not yet issued) entries
- io_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer: head/tail pointers plus a count; pointers wrap modulo DEPTH.
- Enqueue when io_enq_valid && io_enq_ready. io_enq_ready = (count < DEPTH); a full queue does not accept even if a dequeue happens in the same cycle.
- Dequeue (issue) when io_deq_valid && io_deq_ready. Otherwise io_deq_inst/io_deq_sigs stay stable.
- Register fields: rs1=inst[19:15], rs2=inst[24:20], rs3=inst[31:27], rd=inst[11:7].
- FMA scoreboard: shift register of FMA_LAT slots {valid, rd}, shifted every cycle. Issuing an instruction with fma && wen loads slot 0.
- Div/sqrt tracker: ds_busy and ds_rd. Issuing an instruction with div|sqrt sets ds_busy and sets ds_rd = rd. io_divsqrt_done clears ds_busy.
- Pending set = valid FMA slots ∪ {ds_rd if ds_busy && the issuing op had wen}.
- The head stalls on any of the following:
  - RAW: ren1/ren2/ren3 with rs1/rs2/rs3 in the pending set.
  - WAW: wen with rd in the pending set.
  - Structural: (div|sqrt) && ds_busy.
- io_deq_valid = (count≠0) && !stall && !io_kill. The hazard check uses registered scoreboard state only.
- io_kill: count and pointers clear at the next edge. An enqueue in the kill cycle is dropped. The scoreboard and ds_busy are unaffected.

## Timing
- Reset: io_enq_ready=1, io_deq_valid=0, io_count=0, io_deq_inst=0, io_deq_sigs=0. Storage, scoreboard and ds_busy clear.
- Enqueue→visible at head: 1 cycle (no same-cycle bypass into an empty queue).
- Simultaneous enqueue and dequeue with 0<count<DEPTH: count unchanged.
- An FMA issued at edge T is pending during cycles T+1..T+FMA_LAT. A dependent instruction can issue at T+FMA_LAT+1.
- io_divsqrt_done in cycle C: ds_busy falls at edge C. A stalled div/sqrt or dependent head issues in C+1 at the earliest.
- io_divsqrt_done while !ds_busy: ignored.
- Reset asserted mid-operation: all state is cleared immediately; in-flight tracking is lost by design.

## Configuration
- FPU_IQ_SCOREBOARD_EN defined: FMA scoreboard, div/sqrt tracker and stall logic are present as described.
- Not defined: no scoreboard or tracker logic is built. io_deq_valid = (count≠0) && !io_kill, io_divsqrt_done is ignored, and hazards are the consumer's responsibility.

## Test plan
- Fill/drain: enqueue 5 ops back-to-back with io_deq_ready=0. Expect io_enq_ready low after 4, io_count=4, then in-order drain 4→0 with io_deq_ready=1.
- FMA RAW (macro on, FMA_LAT=3): enqueue fmadd.s f3,f1,f2,f4 (0x202081C3, sigs fma|wen|ren1|ren2|ren3), then fadd.s f5,f3,f0 (0x000182D3). fmadd issues at T; fadd issues at exactly T+4.
- Div structural: issue fdiv.s f6,f1,f2; hold a second fdiv at the head. io_deq_valid stays 0 until the cycle after io_divsqrt_done pulses.
- Independent op: with the FMA to f3 pending, fadd.s f7,f1,f2 issues with no stall.
- Kill: with 3 entries and io_enq_valid=1, pulse io_kill. io_deq_valid=0 in that cycle, io_count=0 next cycle, and the enqueued op is dropped.
- Reset mid-stall: assert reset_n=0 while ds_busy=1 and the queue is non-empty. Outputs return to reset values asynchronously, and a div issues freely after release.
